seq_slice_adder_ctrl: RTL and testbench

- Multi-cycle controller that sequences one narrow shared ripple-adder slice over a WIDTH-bit add/subtract, SLICE_W bits per cycle, with a registered carry between slices.
- Sits between the operand source and the result consumer, with valid/ready handshakes on both sides.
- Trades latency for area against the flat 32-bit adder.

---
 rtl/seq_slice_adder_ctrl_pkg.sv | 9 +
 rtl/seq_slice_adder_ctrl_if.sv | 10 +
 rtl/seq_slice_adder_ctrl_slice.sv | 39 +++
 rtl/seq_slice_adder_ctrl.sv | 68 ++++++
 tb/tb_seq_slice_adder_ctrl.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/seq_slice_adder_ctrl_pkg.sv
// seq_slice_adder_ctrl_pkg: shared FSM states, default widths and the slice-index width helper
package seq_slice_adder_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE_W = 8;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seq_slice_adder_ctrl_if.sv
// seq_slice_adder_ctrl_if: operand/result handshake bundle (in_valid/in_ready/a/b/cin/sub, out_valid/out_ready/sum/cout/ovf, busy)
interface seq_slice_adder_ctrl_if
  import seq_slice_adder_ctrl_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);
  logic in_valid, in_ready, cin, sub;
  logic [WIDTH-1:0] a, b, sum;
  logic out_valid, out_ready, cout, ovf, busy;
  modport master(output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout, ovf, busy);
  modport slave(input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout, ovf, busy);
endinterface

// File: rtl/seq_slice_adder_ctrl_slice.sv
// slice_ripple_adder: W-bit ripple adder (x, y, ci -> s, co) from and_gate/and_3 cells
module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module and_3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = a & b & c;
endmodule

module slice_ripple_adder #(parameter int W = 8) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] c;
  assign c[0] = ci;
  assign co = c[W];
  for (genvar i = 0; i < W; i++) begin : g_fa
    logic xy, xc, yc, all;
    and_gate u_xy (.a(x[i]), .b(y[i]), .y(xy));
    and_gate u_xc (.a(x[i]), .b(c[i]), .y(xc));
    and_gate u_yc (.a(y[i]), .b(c[i]), .y(yc));
    and_3    u_all (.a(x[i]), .b(y[i]), .c(c[i]), .y(all));
    assign c[i+1] = xy | xc | yc;
    // odd parity: at least one input set and no carry (exactly one), or all three set
    assign s[i] = ((x[i] | y[i] | c[i]) & ~c[i+1]) | all;
  end
endmodule

// File: rtl/seq_slice_adder_ctrl.sv
// seq_slice_adder_ctrl: sequences one SLICE_W-bit adder over a WIDTH-bit add/sub (clk, rst, bus slave)
module seq_slice_adder_ctrl
  import seq_slice_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input logic clk,
  input logic rst,
  seq_slice_adder_ctrl_if.slave bus
);
  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int IW = idx_w(NUM_SLICES);
  if (WIDTH % SLICE_W != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of SLICE_W");
  end
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic carry, cout_r, ovf_r, last, accept, s_co;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic [SLICE_W-1:0] s_x, s_y, s_s;
  assign s_x = a_r[idx*SLICE_W +: SLICE_W];
  assign s_y = b_r[idx*SLICE_W +: SLICE_W];
  assign last = idx == IW'(NUM_SLICES - 1);
  assign accept = bus.in_valid & bus.in_ready;
  assign bus.sum = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf = ovf_r;
  slice_ripple_adder #(.W(SLICE_W)) u_slice (.x(s_x), .y(s_y), .ci(carry), .s(s_s), .co(s_co));
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy = 1'b0;
    state_nx = (state == IDLE && accept) ? RUN :
               (state == RUN && last) ? DONE :
               (state == DONE && bus.out_ready) ? IDLE : state;
    bus.in_ready = state == IDLE && !rst;
    bus.out_valid = state == DONE;
    bus.busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      carry <= 1'b0;
      sum_r <= '0;
      cout_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (accept) begin
      a_r <= bus.a;
      b_r <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub | bus.cin;
      idx <= '0;
      sum_r <= '0;
      cout_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == RUN) begin
      sum_r[idx*SLICE_W +: SLICE_W] <= s_s;
      carry <= s_co;
      idx <= last ? idx : idx + 1'b1;
      if (last) begin
        cout_r <= s_co;
        ovf_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s_s[SLICE_W-1] != a_r[WIDTH-1]);
      end
    end
  end
endmodule

// File: tb/tb_seq_slice_adder_ctrl.sv
// tb_seq_slice_adder_ctrl: directed table, corner sequences and randomized ops against an arithmetic model
module tb_seq_slice_adder_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seq_slice_adder_ctrl_if bus ();
  seq_slice_adder_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] a, b;
    logic cin, sub;
    logic [31:0] s;
    logic co, ov;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                                output logic [31:0] rs, output logic rc, output logic ro);
    logic [32:0] u;
    longint sr, lim;
    lim = 2147483647;
    u = s ? 33'(a) + 33'h1_0000_0000 - 33'(b) : 33'(a) + 33'(b) + 33'(c);
    sr = s ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    rs = u[31:0];
    rc = u[32];
    ro = sr > lim || sr < -lim - 1;
  endfunction
  task automatic wait_out(input string n);
    int k;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk({n, " latency"}, k, 4);
  endtask
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                        input logic [31:0] es, input logic ec, input logic eo, input string n);
    int k;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk({n, " in_ready"}, bus.in_ready, 1);
    bus.a = a; bus.b = b; bus.cin = c; bus.sub = s; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom); bus.sub = 1'($urandom);
    wait_out(n);
    chk({n, " sum"}, bus.sum, es);
    chk({n, " cout"}, bus.cout, ec);
    chk({n, " ovf"}, bus.ovf, eo);
    chk({n, " busy"}, bus.busy, 1);
    chk({n, " in_ready_done"}, bus.in_ready, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({n, " out_valid_drop"}, bus.out_valid, 0);
    chk({n, " in_ready_back"}, bus.in_ready, 1);
  endtask
  initial begin
    logic [31:0] ra, rb, es;
    logic rc, rs, ec, eo;
    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[5] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst sum", bus.sum, 0);
    chk("rst cout", bus.cout, 0);
    chk("rst ovf", bus.ovf, 0);
    chk("rst busy", bus.busy, 0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", bus.in_ready, 1);
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].s, vecs[i].co, vecs[i].ov, $sformatf("vec%0d", i));
    bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out("bp");
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom);
      @(posedge clk); #1;
      chk("bp out_valid", bus.out_valid, 1);
      chk("bp sum", bus.sum, 32'h2345_6789);
      chk("bp cout", bus.cout, 0);
      chk("bp ovf", bus.ovf, 0);
      chk("bp in_ready", bus.in_ready, 0);
    end
    bus.a = 32'd100; bus.b = 32'd23; bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp release out_valid", bus.out_valid, 0);
    chk("bp release in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp next busy", bus.busy, 1);
    chk("bp next in_ready", bus.in_ready, 0);
    wait_out("bp next");
    chk("bp next sum", bus.sum, 123);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort out_valid", bus.out_valid, 0);
    chk("abort sum", bus.sum, 0);
    chk("abort busy", bus.busy, 0);
    chk("abort in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("abort release in_ready", bus.in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("abort no result", bus.out_valid, 0);
    run_op(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, "after abort");
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      if (i % 4 == 0) rb = {1'b0, ~ra[30:0]};
      model(ra, rb, rc, rs, es, ec, eo);
      run_op(ra, rb, rc, rs, es, ec, eo, $sformatf("rand%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
